// File: rtl/power_pkg.sv
// Shared definitions for the staged power-rail sequencer.
// Contents: FSM state encoding, default stage length, rail count limit,
// and the width of the internal rail level counter.
package power_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    RAMP_UP   = 2'b01,
    ON        = 2'b10,
    RAMP_DOWN = 2'b11
  } power_state_t;

  // One second per rail step at a 100 MHz clock.
  localparam logic [31:0] DEFAULT_STAGE_CYCLES = 32'd100000000;

  localparam int MAX_RAILS = 8;

  // Wide enough to hold 0..MAX_RAILS.
  localparam int LEVEL_W = $clog2(MAX_RAILS + 1);

endpackage

// File: rtl/stage_timer.sv
// 32-bit loadable down-counter used to space rail steps.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset (count -> 0)
//   load          - load count with load_val (takes priority)
//   load_val      - value to load
//   expired       - count is zero
// The counter stops at zero rather than wrapping.
module stage_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/power_sequencer.sv
// Staged power-rail sequencer: enables rails one at a time on power_req,
// disables them in reverse order on release, and drops everything at once
// on force_off (restart blocked until power_req is released).
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   power_req   - level power request, registered before use
//   force_off   - emergency shutdown, acts on the next edge
//   rail_en     - thermometer-coded rail enables from bit 0
//   power_good  - all rails up and settled
//   busy        - ramping up or down
//   locked_out  - force_off seen, waiting for power_req release
module power_sequencer
  import power_pkg::*;
#(
  parameter int          NUM_RAILS    = 3,
  parameter logic [31:0] STAGE_CYCLES = DEFAULT_STAGE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 power_req,
  input  logic                 force_off,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 power_good,
  output logic                 busy,
  output logic                 locked_out
);

  localparam logic [LEVEL_W-1:0] TOP_LEVEL = LEVEL_W'(NUM_RAILS);
  localparam logic [31:0]        RELOAD    = STAGE_CYCLES - 32'd1;

  power_state_t         state, state_next;
  logic [LEVEL_W-1:0]   level, level_next;
  logic                 good_next, locked_next;
  logic                 req_q;
  logic                 timer_load, timer_expired;
  logic [NUM_RAILS-1:0] rail_next;

  stage_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (RELOAD),
    .expired  (timer_expired)
  );

  // The request is registered once, so a change sampled at edge k moves
  // the rails at edge k+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= 1'b0;
      state      <= OFF;
      level      <= '0;
      rail_en    <= '0;
      power_good <= 1'b0;
      busy       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      req_q      <= power_req;
      state      <= state_next;
      level      <= level_next;
      rail_en    <= rail_next;
      power_good <= good_next;
      busy       <= (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
      locked_out <= locked_next;
    end
  end

  always_comb begin
    state_next  = state;
    level_next  = level;
    good_next   = power_good;
    locked_next = locked_out;
    timer_load  = 1'b0;

    if (force_off) begin
      state_next  = OFF;
      level_next  = '0;
      good_next   = 1'b0;
      locked_next = 1'b1;
    end else begin
      case (state)
        OFF: begin
          if (!req_q) begin
            locked_next = 1'b0;
          end else if (!locked_out) begin
            state_next = RAMP_UP;
            level_next = LEVEL_W'(1);
            timer_load = 1'b1;
          end
        end
        RAMP_UP: begin
          if (!req_q) begin
            level_next = level - LEVEL_W'(1);
            timer_load = 1'b1;
            state_next = (level == LEVEL_W'(1)) ? OFF : RAMP_DOWN;
          end else if (timer_expired) begin
            if (level < TOP_LEVEL) begin
              level_next = level + LEVEL_W'(1);
              timer_load = 1'b1;
            end else begin
              state_next = ON;
              good_next  = 1'b1;
            end
          end
        end
        ON: begin
          if (!req_q) begin
            good_next  = 1'b0;
            level_next = level - LEVEL_W'(1);
            timer_load = 1'b1;
            state_next = (level == LEVEL_W'(1)) ? OFF : RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (req_q) begin
            state_next = RAMP_UP;
            level_next = level + LEVEL_W'(1);
            timer_load = 1'b1;
          end else if (timer_expired) begin
            level_next = level - LEVEL_W'(1);
            timer_load = 1'b1;
            if (level == LEVEL_W'(1)) state_next = OFF;
          end
        end
        default: begin
          state_next = OFF;
          level_next = '0;
          good_next  = 1'b0;
        end
      endcase
    end
  end

  // rail_en = (1 << level) - 1, built from the next level so it is registered.
  always_comb begin
    rail_next = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      rail_next[i] = (LEVEL_W'(i) < level_next);
    end
  end

endmodule
